ula_ctrl: RTL and testbench

Sequencing controller for the 4-bit signed ULA datapath. It accepts one ALU instruction at a time over a valid/ready handshake and keeps a 4-entry x 4-bit register file. For each instruction it reads the operands, drives the external ULA's `a`/`b`/`tula` inputs, captures `outp` or `stat`, and writes the result back. It sits between the instruction source (decoder/testbench) and the combinational ULA in the CPU.

---
 rtl/ula_ctrl.sv | 138 +++++++++++++
 tb/tb_ula_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_ctrl.sv
// Sequencing controller for the 4-bit signed ULA: IDLE -> EXEC -> WB per instruction over a 4x4 register file.
// Optional sticky add/sub overflow tracking is built only when ULA_CTRL_OVF_EN is defined.
module ula_ctrl #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    input  logic [8:0]   instr,
    output logic         instr_ready,
    output logic         done,
    input  logic         ld_en,
    input  logic [1:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    input  logic [1:0]   obs_addr,
    output logic [W-1:0] obs_data,
    output logic         flag,
    output logic         ovf,
    output logic [W-1:0] ula_a,
    output logic [W-1:0] ula_b,
    output logic [2:0]   ula_tula,
    input  logic [W-1:0] ula_outp,
    input  logic         ula_stat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t              state;
    logic signed [W-1:0] regs [NREG];
    logic [2:0]          op_p0;
    logic [1:0]          rd_p0;
    logic signed [W-1:0] res_p1;
    logic                stat_p1;

    // Compare ops only update the flag; everything else writes R[rd].
    function automatic logic is_cmp(input logic [2:0] o);
        return (o == 3'b011) || (o == 3'b100) || (o == 3'b101);
    endfunction

    // Reset gates the handshake so nothing is accepted while rst is high.
    assign instr_ready = (state == IDLE) && !rst;
    assign done        = (state == WB) && !rst;
    assign obs_data    = regs[obs_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flag     <= 1'b0;
            ula_a    <= '0;
            ula_b    <= '0;
            ula_tula <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    // Operand fetch happens here so the ULA sees stable inputs for all of EXEC.
                    if (instr_valid && instr_ready) begin
                        ula_a    <= regs[instr[3:2]];
                        ula_b    <= regs[instr[1:0]];
                        ula_tula <= instr[8:6];
                        state    <= EXEC;
                    end else if (ld_en) begin
                        regs[ld_addr] <= ld_data;
                    end
                end
                EXEC: begin
                    ula_a    <= '0;
                    ula_b    <= '0;
                    ula_tula <= '0;
                    state    <= WB;
                end
                WB: begin
                    if (is_cmp(op_p0)) begin
                        flag <= stat_p1;
                    end else begin
                        regs[rd_p0] <= res_p1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage p0: latched instruction fields
    always_ff @(posedge clk) begin
        if (state == IDLE && instr_valid && instr_ready) begin
            op_p0 <= instr[8:6];
            rd_p0 <= instr[5:4];
        end
    end

    // ---- stage p1: captured ULA result and status
    always_ff @(posedge clk) begin
        if (state == EXEC) begin
            res_p1  <= ula_outp;
            stat_p1 <= ula_stat;
        end
    end

`ifdef ULA_CTRL_OVF_EN
    logic ovf_p1;
    logic ovf_q;

    function automatic logic addsub_ovf(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] r);
        if (o == 3'b000) return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        if (o == 3'b001) return (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return 1'b0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_p1 <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state == EXEC) begin
                ovf_p1 <= addsub_ovf(ula_tula, ula_a, ula_b, ula_outp);
            end
            if (state == WB && ovf_p1) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Self-checking bench for ula_ctrl: behavioural ULA, directed table, back-to-back, reset abort, random ops.
module tb_ula_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       done;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic [1:0] obs_addr;
    logic [3:0] obs_data;
    logic       flag;
    logic       ovf;
    logic [3:0] ula_a;
    logic [3:0] ula_b;
    logic [2:0] ula_tula;
    logic [3:0] ula_outp;
    logic       ula_stat;

    int checks = 0;
    int errors = 0;

    logic [3:0] mr [4];
    logic       mflag;
    logic       movf;

    always #20 clk = ~clk;

    ula_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .done(done), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .obs_addr(obs_addr), .obs_data(obs_data), .flag(flag),
        .ovf(ovf), .ula_a(ula_a), .ula_b(ula_b), .ula_tula(ula_tula),
        .ula_outp(ula_outp), .ula_stat(ula_stat)
    );

    // External combinational ULA; compare ops put junk on outp so a bogus writeback shows up.
    always_comb begin
        ula_stat = 1'b0;
        ula_outp = 4'd0;
        case (ula_tula)
            3'b000: ula_outp = ula_a + ula_b;
            3'b001: ula_outp = ula_a - ula_b;
            3'b010: ula_outp = 4'd0 - ula_b;
            3'b011: begin ula_stat = (ula_a == ula_b); ula_outp = ula_a ^ ula_b ^ 4'hA; end
            3'b100: begin ula_stat = ($signed(ula_a) > $signed(ula_b)); ula_outp = ula_a ^ ula_b ^ 4'h5; end
            3'b101: begin ula_stat = ($signed(ula_a) < $signed(ula_b)); ula_outp = ula_a ^ ula_b ^ 4'h3; end
            3'b110: ula_outp = ula_a & ula_b;
            3'b111: ula_outp = ula_a | ula_b;
            default: ula_outp = 4'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            obs_addr = i[1:0];
            #1;
            check($sformatf("%s_R%0d", tag, i), obs_data, mr[i]);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: got timeout expected instr_ready=1");
        end
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        wait_ready();
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(negedge clk);
        ld_en    = 1'b0;
        mr[addr] = data;
        obs_addr = addr;
        #1;
        check($sformatf("load_R%0d", addr), obs_data, data);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs, input logic [1:0] rt);
        int a, b, r;
        logic ov;
        wait_ready();
        instr       = {op, rd, rs, rt};
        instr_valid = 1'b1;
        a  = $signed(mr[rs]);
        b  = $signed(mr[rt]);
        r  = 0;
        ov = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 9'($urandom);
        #1;
        check("exec_done", done, 0);
        check("exec_ready", instr_ready, 0);
        check("exec_a", ula_a, mr[rs]);
        check("exec_b", ula_b, mr[rt]);
        check("exec_tula", ula_tula, op);
        @(negedge clk);
        #1;
        check("wb_done", done, 1);
        check("wb_tula", ula_tula, 0);
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = -b;
            3'd3: mflag = (a == b);
            3'd4: mflag = (a > b);
            3'd5: mflag = (a < b);
            3'd6: r = mr[rs] & mr[rt];
            default: r = mr[rs] | mr[rt];
        endcase
        if (op <= 3'd1 && (r > 7 || r < -8)) ov = 1'b1;
        if (!(op == 3'd3 || op == 3'd4 || op == 3'd5)) mr[rd] = r[3:0];
`ifdef ULA_CTRL_OVF_EN
        movf = movf | ov;
`endif
        @(negedge clk);
        #1;
        check("post_ready", instr_ready, 1);
        check("post_done", done, 0);
        check("post_flag", flag, mflag);
        check("post_ovf", ovf, movf);
        check_regs("post");
    endtask

    typedef struct {
        bit         is_ld;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic [1:0] rt;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; obs_addr = '0;
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        mflag = 1'b0;
        movf  = 1'b0;

        // {is_ld, op, rd, rs, rt, expected R[rd] or flag}
        tbl[0] = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3};
        tbl[1] = '{1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 4'd5};
        tbl[2] = '{1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 4'b1000};
        tbl[3] = '{1'b0, 3'd1, 2'd3, 2'd1, 2'd2, 4'b1110};
        tbl[4] = '{1'b0, 3'd2, 2'd1, 2'd1, 2'd2, 4'b1011};
        tbl[5] = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd3};
        tbl[6] = '{1'b0, 3'd5, 2'd2, 2'd1, 2'd2, 4'd1};
        tbl[7] = '{1'b0, 3'd3, 2'd3, 2'd1, 2'd1, 4'd1};
        tbl[8] = '{1'b0, 3'd4, 2'd0, 2'd1, 2'd2, 4'd0};

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", instr_ready, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1);
        check("rst_flag", flag, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ula_a", ula_a, 0);
        check("rst_ula_b", ula_b, 0);
        check("rst_ula_tula", ula_tula, 0);
        check_regs("rst");

        for (int k = 0; k < 9; k++) begin
            if (tbl[k].is_ld) begin
                load(tbl[k].rd, tbl[k].exp);
            end else begin
                run_instr(tbl[k].op, tbl[k].rd, tbl[k].rs, tbl[k].rt);
                if (tbl[k].op == 3'd3 || tbl[k].op == 3'd4 || tbl[k].op == 3'd5) begin
                    check($sformatf("tbl%0d_flag", k), flag, tbl[k].exp[0]);
                end else begin
                    obs_addr = tbl[k].rd;
                    #1;
                    check($sformatf("tbl%0d_rd", k), obs_data, tbl[k].exp);
                end
            end
        end
`ifdef ULA_CTRL_OVF_EN
        check("ovf_sticky", ovf, 1);
`else
        check("ovf_tied", ovf, 0);
`endif

        // Back-to-back EQ ops with a competing load held on every cycle.
        wait_ready();
        begin
            int acc = 0;
            instr       = {3'b011, 2'd2, 2'd0, 2'd0};
            instr_valid = 1'b1;
            ld_en       = 1'b1;
            ld_addr     = 2'd3;
            ld_data     = ~mr[3];
            for (int c = 0; c < 12; c++) begin
                #1;
                check($sformatf("b2b_ready_c%0d", c), instr_ready, (c % 3 == 0));
                if (instr_ready) acc++;
                @(negedge clk);
            end
            instr_valid = 1'b0;
            ld_en       = 1'b0;
            mflag       = 1'b1;
            #1;
            check("b2b_accepts", acc, 4);
            check("b2b_flag", flag, 1);
            check_regs("b2b");
        end

        // Reset while an ADD to R0 sits in EXEC.
        load(2'd0, 4'd6);
        wait_ready();
        instr       = {3'b000, 2'd0, 2'd1, 2'd2};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        #1;
        check("rstx_in_exec", ula_tula, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rstx_done", done, 0);
        check("rstx_ready_low", instr_ready, 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mr[i] = 4'd0;
        mflag = 1'b0;
        movf  = 1'b0;
        check("rstx_ready", instr_ready, 1);
        check("rstx_flag", flag, 0);
        check("rstx_ovf", ovf, 0);
        check_regs("rstx");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rstx_nodone%0d", c), done, 0);
        end

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(2'($urandom), 4'($urandom));
            end else begin
                run_instr(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
